spi_slave: RTL and testbench

//  SPI slave front-end (mode-0 style, sampled on clk) sitting between an SPI master and a single-port RAM.

---
 rtl/spi_pkg.sv | 32 +++
 rtl/spi_slave_if.sv | 31 +++
 rtl/spi_piso_tx.sv | 84 ++++++++
 rtl/spi_slave.sv | 143 ++++++++++++++
 tb/tb_spi_slave.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// ---------------------------------------------------------------------------
// spi_pkg
// Shared types and constants for the SPI slave front-end.
//   state_e      : front-end state encoding (IDLE..READ_DATA = 0..4)
//   CMD_*        : frame command codes carried in frame bits [9:8]
//   RX_W_DEF     : default rx frame width (2 cmd bits + byte)
//   TX_W_DEF     : default MISO response width
// ---------------------------------------------------------------------------
package spi_pkg;

    localparam int unsigned RX_W_DEF = 10;
    localparam int unsigned TX_W_DEF = 8;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CHK_CMD   = 3'd1,
        ST_WRITE     = 3'd2,
        ST_READ_ADD  = 3'd3,
        ST_READ_DATA = 3'd4
    } state_e;

    // States in which MOSI bits are shifted into the rx frame
    function automatic logic is_shift_state(input state_e s);
        return (s == ST_WRITE) || (s == ST_READ_ADD) || (s == ST_READ_DATA);
    endfunction

endpackage

// File: rtl/spi_slave_if.sv
// ---------------------------------------------------------------------------
// spi_slave_if
// Bundles the SPI serial lines and the RAM-side rx/tx handshake.
//   MOSI, SS_n          : serial input and active-low slave select
//   MISO                : serial output (MSB first)
//   tx_data, tx_valid   : RAM read data into the slave
//   rx_data, rx_valid   : completed frame out of the slave
// Modports: master (SPI master + RAM side), slave (spi_slave).
// ---------------------------------------------------------------------------
interface spi_slave_if #(
    parameter int unsigned RX_W = spi_pkg::RX_W_DEF,
    parameter int unsigned TX_W = spi_pkg::TX_W_DEF
);
    logic            MOSI;
    logic            SS_n;
    logic            MISO;
    logic [TX_W-1:0] tx_data;
    logic            tx_valid;
    logic [RX_W-1:0] rx_data;
    logic            rx_valid;

    modport master (
        output MOSI, SS_n, tx_data, tx_valid,
        input  MISO, rx_data, rx_valid
    );

    modport slave (
        input  MOSI, SS_n, tx_data, tx_valid,
        output MISO, rx_data, rx_valid
    );
endinterface

// File: rtl/spi_piso_tx.sv
// ---------------------------------------------------------------------------
// spi_piso_tx
// Load-once parallel-in/serial-out shifter driving MISO, MSB first.
// After a load the line carries bit W-1 for one cycle, then W-2 .. 0, one
// cycle each, then returns to 0. Only one load is accepted until clear_i.
//   clk, rst   : clock, synchronous active-high reset
//   clear_i    : abort any transfer, re-arm the single load
//   load_i     : request to latch data_i (ignored once used or busy)
//   data_i     : parallel word to send
//   miso_o     : registered serial output
//   last_c_o   : combinational, high in the cycle bit 0 is on the line
// ---------------------------------------------------------------------------
module spi_piso_tx #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear_i,
    input  logic         load_i,
    input  logic [W-1:0] data_i,
    output logic         miso_o,
    output logic         last_c_o
);
    localparam int unsigned CW = $clog2(W);

    logic [W-1:0]  sh_q, sh_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;
    logic          used_q, used_d;
    logic          miso_q, miso_d;

    // Next-state: clear beats shifting, shifting beats a new load
    always_comb begin
        sh_d     = sh_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        used_d   = used_q;
        miso_d   = miso_q;
        last_c_o = busy_q && (cnt_q == '0) && !clear_i;

        if (clear_i) begin
            sh_d   = '0;
            cnt_d  = '0;
            busy_d = 1'b0;
            used_d = 1'b0;
            miso_d = 1'b0;
        end else if (busy_q) begin
            if (cnt_q != '0) begin
                miso_d = sh_q[W-1];
                sh_d   = sh_q << 1;
                cnt_d  = cnt_q - CW'(1);
            end else begin
                miso_d = 1'b0;
                busy_d = 1'b0;
            end
        end else if (load_i && !used_q) begin
            miso_d = data_i[W-1];
            sh_d   = {data_i[W-2:0], 1'b0};
            cnt_d  = CW'(W - 1);
            busy_d = 1'b1;
            used_d = 1'b1;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            sh_q   <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            used_q <= 1'b0;
            miso_q <= 1'b0;
        end else begin
            sh_q   <= sh_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            used_q <= used_d;
            miso_q <= miso_d;
        end
    end

    assign miso_o = miso_q;

endmodule

// File: rtl/spi_slave.sv
// ---------------------------------------------------------------------------
// spi_slave
// SPI slave front-end between an SPI master and a single-port RAM.
// After SS_n falls, one command bit selects WRITE (0) or a read; the read
// goes to READ_ADD until an address frame has been seen, then READ_DATA.
// Each of those states shifts in one RX_W-bit frame (MSB first), publishes it
// on rx_data and pulses rx_valid for one cycle. In READ_DATA the first
// tx_valid after the frame loads tx_data once and serialises it on MISO.
//   clk, rst : clock, synchronous active-high reset
//   bus      : spi_slave_if.slave (MOSI, SS_n, MISO, tx_*, rx_*)
// Optional: define SPI_SLAVE_ASSERT_EN to compile simulation assertions.
// ---------------------------------------------------------------------------
module spi_slave
    import spi_pkg::*;
#(
    parameter int unsigned RX_W = RX_W_DEF,
    parameter int unsigned TX_W = TX_W_DEF
) (
    input  logic        clk,
    input  logic        rst,
    spi_slave_if.slave  bus
);
    localparam int unsigned CNT_W = $clog2(RX_W);

    state_e           cs_q, cs_d;
    logic [RX_W-1:0]  sh_q, sh_d;
    logic [RX_W-1:0]  rx_data_q, rx_data_d;
    logic             rx_valid_q, rx_valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             rd_seen_q, rd_seen_d;
    logic             frame_done_c;

    logic             tx_load_c;
    logic             tx_clear_c;
    logic             tx_last_c;
    logic             miso;

    // Next-state and frame capture
    always_comb begin
        cs_d         = cs_q;
        sh_d         = sh_q;
        rx_data_d    = rx_data_q;
        cnt_d        = cnt_q;
        done_d       = done_q;
        rd_seen_d    = rd_seen_q;
        frame_done_c = 1'b0;

        case (cs_q)
            ST_IDLE: begin
                cnt_d  = '0;
                done_d = 1'b0;
                if (!bus.SS_n) cs_d = ST_CHK_CMD;
            end
            ST_CHK_CMD: begin
                if (bus.SS_n)       cs_d = ST_IDLE;
                else if (!bus.MOSI) cs_d = ST_WRITE;
                else                cs_d = rd_seen_q ? ST_READ_DATA : ST_READ_ADD;
            end
            ST_WRITE, ST_READ_ADD, ST_READ_DATA: begin
                if (bus.SS_n) begin
                    cs_d   = ST_IDLE;
                    cnt_d  = '0;
                    done_d = 1'b0;
                end else if (!done_q) begin
                    // Bits after a complete frame are ignored until SS_n rises
                    sh_d = {sh_q[RX_W-2:0], bus.MOSI};
                    if (cnt_q == CNT_W'(RX_W - 1)) begin
                        rx_data_d    = sh_d;
                        frame_done_c = 1'b1;
                        done_d       = 1'b1;
                        cnt_d        = '0;
                        if (cs_q == ST_READ_ADD) rd_seen_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: cs_d = ST_IDLE;
        endcase

        // A fully transmitted read-data response consumes the address
        if (tx_last_c) rd_seen_d = 1'b0;

        rx_valid_d = frame_done_c;
    end

    // MISO is armed only after the read-data frame has been received
    assign tx_load_c  = (cs_q == ST_READ_DATA) && !bus.SS_n && done_q && bus.tx_valid;
    assign tx_clear_c = bus.SS_n || (cs_q != ST_READ_DATA);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            cs_q       <= ST_IDLE;
            sh_q       <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            cnt_q      <= '0;
            done_q     <= 1'b0;
            rd_seen_q  <= 1'b0;
        end else begin
            cs_q       <= cs_d;
            sh_q       <= sh_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            cnt_q      <= cnt_d;
            done_q     <= done_d;
            rd_seen_q  <= rd_seen_d;
        end
    end

    spi_piso_tx #(
        .W (TX_W)
    ) u_tx (
        .clk      (clk),
        .rst      (rst),
        .clear_i  (tx_clear_c),
        .load_i   (tx_load_c),
        .data_i   (bus.tx_data),
        .miso_o   (miso),
        .last_c_o (tx_last_c)
    );

    assign bus.MISO     = miso;
    assign bus.rx_data  = rx_data_q;
    assign bus.rx_valid = rx_valid_q;

`ifdef SPI_SLAVE_ASSERT_EN
    a_cs_legal: assert property (@(posedge clk) 3'(cs_q) <= 3'd4)
        else $error("cs out of range: %0d", cs_q);

    a_rx_valid_single: assert property (@(posedge clk) disable iff (rst)
        rx_valid_q |=> !rx_valid_q)
        else $error("rx_valid high two consecutive cycles");

    a_rx_valid_source: assert property (@(posedge clk) disable iff (rst)
        (!frame_done_c || !is_shift_state(cs_q)) |=> !rx_valid_q)
        else $error("rx_valid without a completed frame");
`else
`endif

endmodule

// File: tb/tb_spi_slave.sv
module tb_spi_slave;
    import spi_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    spi_slave_if bus ();

    spi_slave dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: last published frame and whether a read address is pending
    logic [9:0] m_last_rx = '0;
    bit         m_rd_seen = 1'b0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_txn(input bit cmd);
        bus.SS_n = 1'b0;
        tick();
        bus.MOSI = cmd;
        tick();
    endtask

    task automatic end_txn();
        bus.SS_n     = 1'b1;
        bus.tx_valid = 1'b0;
        tick();
    endtask

    // Shifts nbits of f (MSB first); records rx_valid pulses and the bit index of the last one
    task automatic send_frame(input logic [9:0] f, input int nbits, input bit rand_tx,
                              output int pulses, output int pos);
        pulses = 0;
        pos    = 0;
        for (int i = 0; i < nbits; i++) begin
            bus.MOSI = f[9-i];
            if (rand_tx) begin
                bus.tx_valid = 1'($urandom);
                bus.tx_data  = 8'($urandom);
            end
            tick();
            if (bus.rx_valid === 1'b1) begin pulses++; pos = i + 1; end
        end
        bus.tx_valid = 1'b0;
        if (nbits == 10) begin
            bus.MOSI = 1'($urandom);
            tick();
            if (bus.rx_valid === 1'b1) begin pulses++; pos = 11; end
        end
    endtask

    // Collects the next 8 MISO bits after presenting b with tx_valid held
    task automatic collect_byte(input logic [7:0] b, output logic [7:0] got);
        bus.tx_data  = b;
        bus.tx_valid = 1'b1;
        for (int k = 7; k >= 0; k--) begin
            tick();
            got[k] = bus.MISO;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.SS_n = 1'b0;
        bus.MOSI = 1'b1;
        repeat (3) tick();
        n_checks++; if (bus.MISO !== 1'b0) begin n_fail++; $display("FAIL reset_miso: got %b want 0", bus.MISO); end
        n_checks++; if (bus.rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rx_valid: got %b want 0", bus.rx_valid); end
        n_checks++; if (bus.rx_data !== 10'h000) begin n_fail++; $display("FAIL reset_rx_data: got %h want 000", bus.rx_data); end
        n_checks++; if (3'(dut.cs_q) !== 3'd0) begin n_fail++; $display("FAIL reset_cs: got %0d want 0", dut.cs_q); end
        rst = 1'b0;
        tick();
        n_checks++; if (3'(dut.cs_q) !== 3'd1) begin n_fail++; $display("FAIL reset_to_chk_cmd: got %0d want 1", dut.cs_q); end
    endtask

    task automatic test_read_addr();
        int p, pos;
        bus.MOSI = 1'b1;
        tick();
        n_checks++; if (3'(dut.cs_q) !== 3'd3) begin n_fail++; $display("FAIL rdaddr_cs: got %0d want 3", dut.cs_q); end
        send_frame(10'h2A5, 10, 1'b0, p, pos);
        m_last_rx = 10'h2A5;
        m_rd_seen = 1'b1;
        n_checks++; if (p !== 1 || pos !== 10) begin n_fail++; $display("FAIL rdaddr_pulse: got %0d pulses at %0d want 1 at 10", p, pos); end
        n_checks++; if (bus.rx_data !== m_last_rx) begin n_fail++; $display("FAIL rdaddr_data: got %h want %h", bus.rx_data, m_last_rx); end
        n_checks++; if (dut.rd_seen_q !== m_rd_seen) begin n_fail++; $display("FAIL rdaddr_seen: got %b want %b", dut.rd_seen_q, m_rd_seen); end
    endtask

    task automatic test_read_data();
        int p, pos, ones;
        logic [7:0] got;
        bus.SS_n = 1'b1;
        tick();
        n_checks++; if (3'(dut.cs_q) !== 3'd0) begin n_fail++; $display("FAIL rddata_idle: got %0d want 0", dut.cs_q); end
        start_txn(1'b1);
        n_checks++; if (3'(dut.cs_q) !== 3'd4) begin n_fail++; $display("FAIL rddata_cs: got %0d want 4", dut.cs_q); end
        send_frame(10'h300, 10, 1'b0, p, pos);
        m_last_rx = 10'h300;
        n_checks++; if (p !== 1 || pos !== 10) begin n_fail++; $display("FAIL rddata_pulse: got %0d pulses at %0d want 1 at 10", p, pos); end
        n_checks++; if (bus.rx_data !== m_last_rx) begin n_fail++; $display("FAIL rddata_data: got %h want %h", bus.rx_data, m_last_rx); end
        collect_byte(8'd81, got);
        n_checks++; if (got !== 8'd81) begin n_fail++; $display("FAIL rddata_miso: got %b want %b", got, 8'd81); end
        m_rd_seen = 1'b0;
        ones = 0;
        repeat (5) begin tick(); if (bus.MISO !== 1'b0) ones++; end
        n_checks++; if (ones !== 0) begin n_fail++; $display("FAIL rddata_no_reload: got %0d nonzero MISO cycles want 0", ones); end
        n_checks++; if (dut.rd_seen_q !== m_rd_seen) begin n_fail++; $display("FAIL rddata_seen: got %b want %b", dut.rd_seen_q, m_rd_seen); end
        end_txn();
    endtask

    task automatic test_write();
        int p, pos;
        logic [9:0] frames [2];
        frames[0] = 10'h03C;
        frames[1] = 10'h1FF;
        for (int i = 0; i < 2; i++) begin
            start_txn(1'b0);
            n_checks++; if (3'(dut.cs_q) !== 3'd2) begin n_fail++; $display("FAIL write_cs%0d: got %0d want 2", i, dut.cs_q); end
            send_frame(frames[i], 10, 1'b0, p, pos);
            m_last_rx = frames[i];
            n_checks++; if (p !== 1 || pos !== 10) begin n_fail++; $display("FAIL write_pulse%0d: got %0d pulses at %0d want 1 at 10", i, p, pos); end
            n_checks++; if (bus.rx_data !== m_last_rx) begin n_fail++; $display("FAIL write_data%0d: got %h want %h", i, bus.rx_data, m_last_rx); end
            end_txn();
        end
        repeat (3) tick();
        n_checks++; if (bus.rx_data !== m_last_rx) begin n_fail++; $display("FAIL write_hold: got %h want %h", bus.rx_data, m_last_rx); end
    endtask

    task automatic test_abort();
        int p, pos;
        logic [7:0] got;
        start_txn(1'b0);
        send_frame(10'h2AA, 5, 1'b0, p, pos);
        bus.SS_n = 1'b1;
        tick();
        n_checks++; if (3'(dut.cs_q) !== 3'd0) begin n_fail++; $display("FAIL abort_cs: got %0d want 0", dut.cs_q); end
        n_checks++; if (p !== 0 || bus.rx_valid !== 1'b0) begin n_fail++; $display("FAIL abort_pulse: got %0d pulses want 0", p); end
        n_checks++; if (bus.rx_data !== m_last_rx) begin n_fail++; $display("FAIL abort_hold: got %h want %h", bus.rx_data, m_last_rx); end

        // SS_n abort mid-response: MISO drops, pending read address survives
        start_txn(1'b1);
        send_frame(10'h280, 10, 1'b0, p, pos);
        end_txn();
        start_txn(1'b1);
        send_frame(10'h3FF, 10, 1'b0, p, pos);
        m_last_rx = 10'h3FF;
        m_rd_seen = 1'b1;
        bus.tx_data  = 8'hFF;
        bus.tx_valid = 1'b1;
        repeat (3) tick();
        n_checks++; if (bus.MISO !== 1'b1) begin n_fail++; $display("FAIL abort_miso_active: got %b want 1", bus.MISO); end
        end_txn();
        n_checks++; if (bus.MISO !== 1'b0) begin n_fail++; $display("FAIL abort_miso_drop: got %b want 0", bus.MISO); end
        n_checks++; if (dut.rd_seen_q !== m_rd_seen) begin n_fail++; $display("FAIL abort_seen_kept: got %b want %b", dut.rd_seen_q, m_rd_seen); end

        // Reset mid-response
        start_txn(1'b1);
        n_checks++; if (3'(dut.cs_q) !== 3'd4) begin n_fail++; $display("FAIL rstmid_cs4: got %0d want 4", dut.cs_q); end
        send_frame(10'h3C3, 10, 1'b0, p, pos);
        collect_byte(8'hFF, got);
        rst = 1'b1;
        tick();
        bus.SS_n     = 1'b1;
        bus.tx_valid = 1'b0;
        m_last_rx    = '0;
        m_rd_seen    = 1'b0;
        n_checks++; if (bus.MISO !== 1'b0) begin n_fail++; $display("FAIL rstmid_miso: got %b want 0", bus.MISO); end
        n_checks++; if (3'(dut.cs_q) !== 3'd0) begin n_fail++; $display("FAIL rstmid_cs: got %0d want 0", dut.cs_q); end
        rst = 1'b0;
        tick();
        n_checks++; if (dut.rd_seen_q !== m_rd_seen) begin n_fail++; $display("FAIL rstmid_seen: got %b want %b", dut.rd_seen_q, m_rd_seen); end
        n_checks++; if (bus.rx_data !== m_last_rx) begin n_fail++; $display("FAIL rstmid_rx_data: got %h want %h", bus.rx_data, m_last_rx); end
    endtask

    task automatic test_random();
        int p, pos, nb, d, ones;
        bit cmd, abort;
        logic [2:0] exp_cs;
        logic [9:0] f;
        logic [7:0] b, got;
        for (int it = 0; it < 40; it++) begin
            cmd    = 1'($urandom_range(0, 1));
            exp_cs = !cmd ? 3'd2 : (m_rd_seen ? 3'd4 : 3'd3);
            start_txn(cmd);
            n_checks++; if (3'(dut.cs_q) !== exp_cs) begin n_fail++; $display("FAIL rand%0d_cs: got %0d want %0d", it, dut.cs_q, exp_cs); end
            f     = 10'($urandom);
            abort = ($urandom_range(0, 3) == 0);
            nb    = abort ? int'($urandom_range(1, 9)) : 10;
            send_frame(f, nb, 1'b1, p, pos);
            if (abort) begin
                n_checks++; if (p !== 0 || bus.rx_data !== m_last_rx) begin n_fail++; $display("FAIL rand%0d_abort: got %0d pulses data %h want 0 pulses data %h", it, p, bus.rx_data, m_last_rx); end
            end else begin
                m_last_rx = f;
                if (exp_cs == 3'd3) m_rd_seen = 1'b1;
                n_checks++; if (p !== 1 || pos !== 10 || bus.rx_data !== m_last_rx) begin n_fail++; $display("FAIL rand%0d_frame: got %0d pulses at %0d data %h want 1 at 10 data %h", it, p, pos, bus.rx_data, m_last_rx); end
                if (exp_cs == 3'd4) begin
                    d = int'($urandom_range(0, 3));
                    ones = 0;
                    repeat (d) begin tick(); if (bus.MISO !== 1'b0) ones++; end
                    b = 8'($urandom);
                    collect_byte(b, got);
                    m_rd_seen = 1'b0;
                    tick();
                    if (bus.MISO !== 1'b0) ones++;
                    n_checks++; if (got !== b || ones !== 0) begin n_fail++; $display("FAIL rand%0d_miso: got %b (%0d stray) want %b", it, got, ones, b); end
                end
            end
            end_txn();
            n_checks++; if (dut.rd_seen_q !== m_rd_seen) begin n_fail++; $display("FAIL rand%0d_seen: got %b want %b", it, dut.rd_seen_q, m_rd_seen); end
        end
    endtask

    initial begin
        bus.MOSI     = 1'b0;
        bus.SS_n     = 1'b1;
        bus.tx_data  = '0;
        bus.tx_valid = 1'b0;
        rst          = 1'b1;
        test_reset();
        test_read_addr();
        test_read_data();
        test_write();
        test_abort();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
